regwrite_arbiter: RTL and testbench

Arbiter and sequencer for the register file's single write port in the single-cycle datapath. It accepts write requests from up to NREQ writeback sources, such as ALU result, load data and jump-and-link return address. Each clock it grants at most one source and drives the registered write address, enable and data. The address and enable go straight to the 5-to-32 write-select decoder (`x`, `en`); the data goes to the register array.

---
 rtl/regwrite_arbiter.sv | 120 ++++++++++++
 tb/tb_regwrite_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: grants one of NREQ writeback sources per cycle with lock support.
// Define REGWR_RR_ARB_EN for round-robin priority; otherwise requester 0 has fixed highest priority.
module regwrite_arbiter #(
   parameter int NREQ     = 3,
   parameter int AW       = 5,
   parameter int DW       = 32,
   parameter int LOCK_MAX = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] data,
   output logic [NREQ-1:0]    gnt,
   output logic               wr_en,
   output logic [AW-1:0]      wr_addr,
   output logic [DW-1:0]      wr_data,
   output logic               busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [3:0] LMAX = 4'(LOCK_MAX);

   typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

   state_t          state, state_n;
   logic [PW-1:0]   ptr, ptr_n;
   logic [3:0]      lock_cnt, lock_cnt_n;
   logic [NREQ-1:0] elig, gnt_n;
   logic            found, relock, wr_en_n;
   logic [PW-1:0]   win;
   logic [AW-1:0]   win_addr, wr_addr_n;
   logic [DW-1:0]   win_data, wr_data_n;

   // The current holder only competes again through lock, and only below the lock limit.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NREQ; i++)
         elig[i] = req[i] & (~gnt[i] | (lock[i] & (lock_cnt < LMAX)));
   end

   always_comb begin : pick
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
`ifdef REGWR_RR_ARB_EN
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
`else
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (elig[k]) begin
            found = 1'b1;
            win   = PW'(k);
         end
      end
`endif
   end

   assign win_addr = addr[int'(win)*AW +: AW];
   assign win_data = data[int'(win)*DW +: DW];
   // A winner that already holds gnt can only have got there through lock.
   assign relock   = found & gnt[win];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (!found)      state_n = IDLE;
      else if (relock) state_n = LOCKED;
      else             state_n = GRANT;
   end

   always_comb begin
      gnt_n      = '0;
      wr_en_n    = 1'b0;
      wr_addr_n  = wr_addr;
      wr_data_n  = wr_data;
      lock_cnt_n = '0;
      ptr_n      = ptr;
      if (state_n != IDLE) begin
         gnt_n      = NREQ'(1) << win;
         wr_en_n    = (win_addr != '0);
         wr_addr_n  = win_addr;
         wr_data_n  = win_data;
         lock_cnt_n = (state_n == LOCKED) ? lock_cnt + 4'd1 : 4'd1;
         ptr_n      = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt      <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         busy     <= 1'b0;
         lock_cnt <= '0;
         ptr      <= '0;
      end else begin
         gnt      <= gnt_n;
         wr_en    <= wr_en_n;
         wr_addr  <= wr_addr_n;
         wr_data  <= wr_data_n;
         busy     <= |gnt_n;
         lock_cnt <= lock_cnt_n;
         ptr      <= ptr_n;
      end
   end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter; expected outputs are queued as stimulus is applied and popped after each edge.
module tb_regwrite_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req, lock, gnt;
   logic [14:0] addr;
   logic [95:0] data;
   logic        wr_en, busy;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   logic [4:0]  ta [3];
   logic [31:0] td [3];

   typedef struct packed {
      logic [2:0]  g;
      logic        en;
      logic [4:0]  a;
      logic [31:0] d;
      logic        b;
   } obs_t;

   obs_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [4:0]  last_a;
   logic [31:0] last_d;

   assign addr = {ta[2], ta[1], ta[0]};
   assign data = {td[2], td[1], td[0]};

   always #5 clk = ~clk;

   regwrite_arbiter dut (
      .clk(clk), .reset(reset), .req(req), .lock(lock), .addr(addr), .data(data),
      .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   task automatic expect_out(input logic [2:0] g, input logic en, input logic [4:0] a, input logic [31:0] d);
      obs_t e;
      e.g = g; e.en = en; e.a = a; e.d = d; e.b = (g != 3'b000);
      sb.push_back(e);
   endtask

   task automatic check(input string tag);
      obs_t e, o;
      e = sb.pop_front();
      o.g = gnt; o.en = wr_en; o.a = wr_addr; o.d = wr_data; o.b = busy;
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed gnt=%b en=%b addr=%0d data=%h busy=%b expected gnt=%b en=%b addr=%0d data=%h busy=%b",
                tag, o.g, o.en, o.a, o.d, o.b, e.g, e.en, e.a, e.d, e.b);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1 check(tag);
   endtask

   task automatic grant(input string tag, input int i);
      expect_out(3'(1 << i), ta[i] != 5'd0, ta[i], td[i]);
      last_a = ta[i];
      last_d = td[i];
      step(tag);
   endtask

   task automatic idle(input string tag);
      expect_out(3'b000, 1'b0, last_a, last_d);
      step(tag);
   endtask

   initial begin
      reset = 1'b1; req = 3'b111; lock = 3'b000;
      ta[0] = 5'd7;  td[0] = 32'hDEADBEEF;
      ta[1] = 5'd9;  td[1] = 32'h1111_0001;
      ta[2] = 5'd12; td[2] = 32'h2222_0002;
      last_a = '0; last_d = '0;

      // reset holds everything at zero even with all requests up
      #1 expect_out(3'b000, 1'b0, 5'd0, 32'd0); check("rst_async");
      idle("rst_hold0");
      idle("rst_hold1");
      @(negedge clk) reset = 1'b0;
      grant("rst_first", 0);
      req = 3'b000;
      idle("rst_idle");

      req = 3'b001;
      grant("single", 0);
      req = 3'b000;
      idle("single_drop");

      // park ptr at 0 before contention
      req = 3'b100;
      grant("park", 2);
      req = 3'b000;
      idle("park_idle");

      req = 3'b111;
      for (int k = 0; k < 6; k++) begin
`ifdef REGWR_RR_ARB_EN
         grant($sformatf("cont_rr%0d", k), k % 3);
`else
         grant($sformatf("cont_fp%0d", k), k % 2);
`endif
      end
      req = 3'b000;
      idle("cont_idle");

      req = 3'b011; lock = 3'b001;
      for (int k = 0; k < 4; k++) grant($sformatf("lock_hold%0d", k), 0);
      grant("lock_release", 1);
      grant("lock_regain", 0);
      req = 3'b000; lock = 3'b000;
      idle("lock_idle");

      req = 3'b001; lock = 3'b001;
      for (int k = 0; k < 4; k++) grant($sformatf("solo_hold%0d", k), 0);
      idle("solo_forced_idle");
      grant("solo_regain", 0);
      req = 3'b000; lock = 3'b000;
      idle("solo_idle");

      ta[0] = 5'd0;
      req = 3'b001;
      grant("reg0_write", 0);
      req = 3'b000;
      idle("reg0_idle");
      ta[0] = 5'd7;

      req = 3'b001; lock = 3'b001;
      grant("mid_new", 0);
      grant("mid_lock1", 0);
      grant("mid_lock2", 0);
      #2 reset = 1'b1;
      last_a = '0; last_d = '0;
      #1 idle_now("mid_rst_async");
      idle("mid_rst_hold");
      @(negedge clk) reset = 1'b0;
      for (int k = 0; k < 4; k++) grant($sformatf("post_rst_hold%0d", k), 0);
      idle("post_rst_forced_idle");
      grant("post_rst_regain", 0);
      req = 3'b000; lock = 3'b000;
      idle("end_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic idle_now(input string tag);
      expect_out(3'b000, 1'b0, last_a, last_d);
      check(tag);
   endtask

endmodule
